riscv_exec_unit: RTL

Parametrised integer execute unit for the RV32I/RV64I core, sitting between decode and writeback. It is the multi-cycle successor to the single-cycle ALU and branch-compare decode, generalised to XLEN of 32 or 64. It adds a valid/ready handshake and an iterative shifter with a configurable step size to trade area for latency. It evaluates every ALU function and branch condition defined in `riscv_pkg`.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/riscv_exec_unit_if.sv | 26 ++
 rtl/riscv_serial_shifter.sv | 58 +++++
 rtl/riscv_exec_unit.sv | 123 ++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I/RV64I decode constants and execute-unit types.
package riscv_pkg;

    localparam int XlenRv32 = 32;
    localparam int XlenRv64 = 64;

    // ALU codes are {funct7, funct3}
    localparam logic [9:0] AluAdd  = 10'b0000000_000;
    localparam logic [9:0] AluSub  = 10'b0100000_000;
    localparam logic [9:0] AluSll  = 10'b0000000_001;
    localparam logic [9:0] AluSlt  = 10'b0000000_010;
    localparam logic [9:0] AluSltu = 10'b0000000_011;
    localparam logic [9:0] AluXor  = 10'b0000000_100;
    localparam logic [9:0] AluSrl  = 10'b0000000_101;
    localparam logic [9:0] AluSra  = 10'b0100000_101;
    localparam logic [9:0] AluOr   = 10'b0000000_110;
    localparam logic [9:0] AluAnd  = 10'b0000000_111;

    localparam logic [2:0] BrEq  = 3'b000;
    localparam logic [2:0] BrNe  = 3'b001;
    localparam logic [2:0] BrLt  = 3'b100;
    localparam logic [2:0] BrGe  = 3'b101;
    localparam logic [2:0] BrLtu = 3'b110;
    localparam logic [2:0] BrGeu = 3'b111;

    typedef enum logic {ModeAlu = 1'b0, ModeBranch = 1'b1} exec_mode_e;

    typedef enum logic [1:0] {ExIdle, ExShift, ExDone} exec_state_e;

    typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shift_kind_e;

endpackage

// File: rtl/riscv_exec_unit_if.sv
// Request/result handshake bundle between decode, the execute unit and writeback.
interface riscv_exec_unit_if #(parameter int XLEN = 32);
    import riscv_pkg::*;

    logic            i_valid;
    logic            o_ready;
    exec_mode_e      i_mode;
    logic [9:0]      i_funct;
    logic [XLEN-1:0] i_a;
    logic [XLEN-1:0] i_b;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_result;
    logic            o_taken;
    logic            o_illegal;

    modport slave (
        input  i_valid, i_mode, i_funct, i_a, i_b, i_ready,
        output o_ready, o_valid, o_result, o_taken, o_illegal
    );

    modport master (
        output i_valid, i_mode, i_funct, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_result, o_taken, o_illegal
    );
endinterface

// File: rtl/riscv_serial_shifter.sv
// Iterative shifter: moves at most SHIFT_STEP bits per cycle until the count drains.
// done is asserted during the final shift cycle; result then carries the finished value.
module riscv_serial_shifter
    import riscv_pkg::*;
#(
    parameter int XLEN       = XlenRv32,
    parameter int SHIFT_STEP = 1,
    localparam int CW        = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  shift_kind_e     kind,
    input  logic [XLEN-1:0] data,
    input  logic [CW-1:0]   shamt,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    logic [XLEN-1:0] acc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   k;
    shift_kind_e     kind_q;

    // count < XLEN, so whenever SHIFT_STEP is picked it is below XLEN and fits CW bits
    always_comb begin
        k = count;
        if ({1'b0, count} > (CW+1)'(SHIFT_STEP)) k = CW'(SHIFT_STEP);
    end

    // SRA keeps the sign in the accumulator MSB, so each step refills with the original sign
    always_comb begin
        result = acc >> k;
        case (kind_q)
            ShSll:   result = acc << k;
            ShSra:   result = $unsigned($signed(acc) >>> k);
            default: result = acc >> k;
        endcase
    end

    assign busy = (count != '0);
    assign done = busy && (count == k);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            count  <= '0;
            kind_q <= ShSll;
        end else if (start) begin
            acc    <= data;
            count  <= shamt;
            kind_q <= kind;
        end else if (busy) begin
            acc    <= result;
            count  <= count - k;
        end
    end
endmodule

// File: rtl/riscv_exec_unit.sv
// Integer execute unit: single-cycle ALU/branch compare plus an iterative shifter behind a valid/ready FSM.
// Results are registered and held in DONE until the consumer takes them.
module riscv_exec_unit
    import riscv_pkg::*;
#(
    parameter int XLEN       = XlenRv32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    riscv_exec_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    exec_state_e     state_q, state_d;
    logic [XLEN-1:0] alu_res, result_q, sh_result;
    logic            taken, illegal, is_shift;
    logic            taken_q, illegal_q;
    shift_kind_e     sh_kind;
    logic            sh_start, sh_busy, sh_done;
    logic [CW-1:0]   shamt;
    logic            accept;

    assign shamt  = bus.i_b[CW-1:0];
    assign accept = bus.i_valid && (state_q == ExIdle);

    always_comb begin
        alu_res  = '0;
        taken    = 1'b0;
        illegal  = 1'b0;
        is_shift = 1'b0;
        sh_kind  = ShSll;
        if (bus.i_mode == ModeBranch) begin
            case (bus.i_funct[2:0])
                BrEq:    taken = (bus.i_a == bus.i_b);
                BrNe:    taken = (bus.i_a != bus.i_b);
                BrLt:    taken = ($signed(bus.i_a) <  $signed(bus.i_b));
                BrGe:    taken = ($signed(bus.i_a) >= $signed(bus.i_b));
                BrLtu:   taken = (bus.i_a <  bus.i_b);
                BrGeu:   taken = (bus.i_a >= bus.i_b);
                default: illegal = 1'b1;
            endcase
        end else begin
            case (bus.i_funct)
                AluAdd:  alu_res = bus.i_a + bus.i_b;
                AluSub:  alu_res = bus.i_a - bus.i_b;
                AluSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.i_a) < $signed(bus.i_b)};
                AluSltu: alu_res = {{(XLEN-1){1'b0}}, bus.i_a < bus.i_b};
                AluXor:  alu_res = bus.i_a ^ bus.i_b;
                AluOr:   alu_res = bus.i_a | bus.i_b;
                AluAnd:  alu_res = bus.i_a & bus.i_b;
                // a zero shamt finishes immediately with the operand itself
                AluSll:  begin is_shift = 1'b1; alu_res = bus.i_a; sh_kind = ShSll; end
                AluSrl:  begin is_shift = 1'b1; alu_res = bus.i_a; sh_kind = ShSrl; end
                AluSra:  begin is_shift = 1'b1; alu_res = bus.i_a; sh_kind = ShSra; end
                default: illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_start = 1'b0;
        case (state_q)
            ExIdle: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        sh_start = 1'b1;
                        state_d  = ExShift;
                    end else begin
                        state_d  = ExDone;
                    end
                end
            end
            // the idle-shifter exit only matters if the counter was somehow lost
            ExShift: begin
                if (sh_done)       state_d = ExDone;
                else if (!sh_busy) state_d = ExIdle;
            end
            ExDone:  if (bus.i_ready) state_d = ExIdle;
            default: state_d = ExIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ExIdle;
            result_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                result_q  <= alu_res;
                taken_q   <= taken;
                illegal_q <= illegal;
            end else if ((state_q == ExShift) && sh_done) begin
                result_q  <= sh_result;
            end
        end
    end

    riscv_serial_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .start  (sh_start),
        .kind   (sh_kind),
        .data   (bus.i_a),
        .shamt  (shamt),
        .busy   (sh_busy),
        .done   (sh_done),
        .result (sh_result)
    );

    assign bus.o_ready   = (state_q == ExIdle);
    assign bus.o_valid   = (state_q == ExDone);
    assign bus.o_result  = result_q;
    assign bus.o_taken   = taken_q;
    assign bus.o_illegal = illegal_q;
endmodule
